// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the helper that sizes the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter must hold 0..WIDTH, never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Half-subtractor cell: diff = a ^ b, borrow out = ~a & b.
// Two of these plus an OR form one full-subtract bit slice.
module half_subtractor (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b
);

  assign diff  = a ^ b;
  assign b_out = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock,
// with start/ready/done handshake and borrow/overflow/zero flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_zero;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_hs0_d;
  logic             w_hs0_b;
  logic             w_hs1_b;
  logic             w_bit_d;
  logic             w_bit_br;

  // Full-subtract slice on the current LSBs and the registered borrow.
  half_subtractor u_hs0 (
    .diff  (w_hs0_d),
    .b_out (w_hs0_b),
    .a     (r_a[0]),
    .b     (r_b[0])
  );

  half_subtractor u_hs1 (
    .diff  (w_bit_d),
    .b_out (w_hs1_b),
    .a     (w_hs0_d),
    .b     (r_br)
  );

  assign w_bit_br = w_hs0_b | w_hs1_b;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // The minuend register doubles as the working difference: each consumed
  // minuend bit frees the MSB slot that receives the new difference bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign w_a_shift[gi] = w_bit_d;
        assign w_b_shift[gi] = 1'b0;
      end else begin : g_mid
        assign w_a_shift[gi] = r_a[gi+1];
        assign w_b_shift[gi] = r_b[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_br       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_step) begin
      r_a   <= w_a_shift;
      r_b   <= w_b_shift;
      r_br  <= w_bit_br;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff     <= w_a_shift;
        r_borrow   <= w_bit_br;
        r_overflow <= (r_a_msb != r_b_msb) && (w_a_shift[WIDTH-1] != r_a_msb);
        r_zero     <= ~|w_a_shift;
      end
    end
  end

  assign ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy     = (r_state == ST_SHIFT);
  assign done     = (r_state == ST_DONE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule
